// File: rtl/hps_csr_pkg.sv
// Shared register map, field positions and the CTRL register layout for the HPS CSR bank.
package hps_csr_pkg;

  localparam int unsigned ADDR_CTRL        = 0;
  localparam int unsigned ADDR_DRIVE       = 1;
  localparam int unsigned ADDR_IRQ_STATUS  = 2;
  localparam int unsigned ADDR_IRQ_MASK    = 3;
  localparam int unsigned ADDR_TURN_PERIOD = 4;
  localparam int unsigned ADDR_TURN_COUNT  = 5;

  localparam int unsigned CTRL_RST_OUT      = 0;
  localparam int unsigned CTRL_NEW_FRAME    = 1;
  localparam int unsigned CTRL_FORCE_FC     = 2;
  localparam int unsigned CTRL_HPS_OVERRIDE = 3;
  localparam int unsigned CTRL_PD_EN        = 4;

  localparam int unsigned DRIVE_LAT      = 0;
  localparam int unsigned DRIVE_SCLK     = 1;
  localparam int unsigned DRIVE_TICK     = 2;
  localparam int unsigned DRIVE_SOUT_LSB = 4;

  localparam int unsigned TURN_COUNT_WIDTH = 32;

  // Field order puts rst_out at bit 0 so the struct maps straight onto the CTRL word.
  typedef struct packed {
    logic pd_en;
    logic hps_override;
    logic force_fc;
    logic new_frame;
    logic rst_out;
  } ctrl_t;

endpackage

// File: rtl/hps_edge_sync.sv
// Two-flop synchroniser for one asynchronous event line, followed by a single-cycle
// rising- or falling-edge pulse selected by DETECT_FALL.
module hps_edge_sync #(
  parameter bit DETECT_FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_c = DETECT_FALL ? (prev_q & ~sync_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/hps_csr_bank.sv
// HPS control/status register bank: control and override drive registers, W1C event status
// with mask, and an optional turn-period meter enabled by HPS_CSR_TURN_PERIOD_EN.
module hps_csr_bank
  import hps_csr_pkg::*;
#(
  parameter int unsigned W_ADDR_WIDTH = 3,
  parameter int unsigned W_DATA_WIDTH = 32,
  parameter int unsigned NB_LED_BAND  = 20,
  parameter int unsigned NB_IRQ       = 4,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NB_IRQ-1:0]       irq_src,
  input  logic [W_ADDR_WIDTH-1:0] w_addr,
  input  logic [W_DATA_WIDTH-1:0] w_data,
  input  logic                    write,
  input  logic [W_ADDR_WIDTH-1:0] r_addr,
  input  logic                    read,
  output logic [W_DATA_WIDTH-1:0] r_data,
  output logic                    r_valid,
  output logic                    rst_out,
  output logic                    new_frame,
  output logic                    force_fc,
  output logic                    hps_override,
  output logic                    PD,
  output logic [NB_LED_BAND-1:0]  hps_SOUT,
  output logic                    hps_LAT,
  output logic                    hps_SCLK,
  output logic                    hps_turn_tick,
  output logic                    irq
);

  ctrl_t                   ctrl_q;
  logic                    pd_q;
  logic [NB_LED_BAND-1:0]  sout_q;
  logic                    lat_q;
  logic                    sclk_q;
  logic                    tick_q;
  logic [NB_IRQ-1:0]       status_q;
  logic [NB_IRQ-1:0]       status_d_c;
  logic [NB_IRQ-1:0]       mask_q;
  logic [NB_IRQ-1:0]       edge_c;
  logic [W_DATA_WIDTH-1:0] rd_word_c;
  logic [W_DATA_WIDTH-1:0] turn_period_rd_c;
  logic [W_DATA_WIDTH-1:0] turn_count_rd_c;
  logic                    wr_ctrl_c;
  logic                    wr_drive_c;
  logic                    wr_status_c;
  logic                    wr_mask_c;
  logic                    unused_c;

  assign wr_ctrl_c   = write && (w_addr == W_ADDR_WIDTH'(ADDR_CTRL));
  assign wr_drive_c  = write && (w_addr == W_ADDR_WIDTH'(ADDR_DRIVE));
  assign wr_status_c = write && (w_addr == W_ADDR_WIDTH'(ADDR_IRQ_STATUS));
  assign wr_mask_c   = write && (w_addr == W_ADDR_WIDTH'(ADDR_IRQ_MASK));

  // Upper write-data bits beyond the widest field carry no state.
  assign unused_c = ^w_data;

  // Bit 0 (turn_tick) reports its falling edge; the other sources report rising edges.
  for (genvar i = 0; i < NB_IRQ; i++) begin : g_sync
    hps_edge_sync #(
      .DETECT_FALL (1'(i == 0))
    ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (irq_src[i]),
      .pulse_c  (edge_c[i])
    );
  end

  // Control and override drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      pd_q   <= 1'b1;
      sout_q <= '0;
      lat_q  <= 1'b0;
      sclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        ctrl_q.rst_out      <= w_data[CTRL_RST_OUT];
        ctrl_q.new_frame    <= w_data[CTRL_NEW_FRAME];
        ctrl_q.force_fc     <= w_data[CTRL_FORCE_FC];
        ctrl_q.hps_override <= w_data[CTRL_HPS_OVERRIDE];
        ctrl_q.pd_en        <= w_data[CTRL_PD_EN];
        pd_q                <= ~w_data[CTRL_PD_EN];
      end
      if (wr_drive_c) begin
        lat_q  <= w_data[DRIVE_LAT];
        sclk_q <= w_data[DRIVE_SCLK];
        tick_q <= w_data[DRIVE_TICK];
        sout_q <= w_data[NB_LED_BAND+DRIVE_SOUT_LSB-1:DRIVE_SOUT_LSB];
      end
    end
  end

  // New edges are OR'd in after the W1C clear so a coincident event is never lost.
  always_comb begin
    status_d_c = status_q;
    if (wr_status_c) begin
      status_d_c = status_q & ~w_data[NB_IRQ-1:0];
    end
    status_d_c = status_d_c | edge_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= status_d_c;
      if (wr_mask_c) begin
        mask_q <= w_data[NB_IRQ-1:0];
      end
      irq <= |(status_q & mask_q);
    end
  end

`ifdef HPS_CSR_TURN_PERIOD_EN
  logic [PERIOD_WIDTH-1:0]     period_cnt_q;
  logic [PERIOD_WIDTH-1:0]     turn_period_q;
  logic [TURN_COUNT_WIDTH-1:0] turn_count_q;

  // Counter restarts at 1 on the fall so the captured value equals the clocks between falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q  <= '0;
      turn_period_q <= '0;
      turn_count_q  <= '0;
    end else if (edge_c[0]) begin
      turn_period_q <= period_cnt_q;
      period_cnt_q  <= PERIOD_WIDTH'(1);
      turn_count_q  <= turn_count_q + TURN_COUNT_WIDTH'(1);
    end else if (period_cnt_q != '1) begin
      period_cnt_q <= period_cnt_q + PERIOD_WIDTH'(1);
    end
  end

  assign turn_period_rd_c = W_DATA_WIDTH'(turn_period_q);
  assign turn_count_rd_c  = W_DATA_WIDTH'(turn_count_q);
`else
  assign turn_period_rd_c = '0;
  assign turn_count_rd_c  = '0;
`endif

  // Read mux sees pre-write register values, so a same-cycle write returns the old word.
  always_comb begin
    rd_word_c = '0;
    case (r_addr)
      W_ADDR_WIDTH'(ADDR_CTRL):        rd_word_c = W_DATA_WIDTH'(ctrl_q);
      W_ADDR_WIDTH'(ADDR_DRIVE):       rd_word_c = W_DATA_WIDTH'({sout_q, 1'b0, tick_q, sclk_q, lat_q});
      W_ADDR_WIDTH'(ADDR_IRQ_STATUS):  rd_word_c = W_DATA_WIDTH'(status_q);
      W_ADDR_WIDTH'(ADDR_IRQ_MASK):    rd_word_c = W_DATA_WIDTH'(mask_q);
      W_ADDR_WIDTH'(ADDR_TURN_PERIOD): rd_word_c = turn_period_rd_c;
      W_ADDR_WIDTH'(ADDR_TURN_COUNT):  rd_word_c = turn_count_rd_c;
      default:                         rd_word_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= read;
      if (read) begin
        r_data <= rd_word_c;
      end
    end
  end

  assign rst_out       = ctrl_q.rst_out;
  assign new_frame     = ctrl_q.new_frame;
  assign force_fc      = ctrl_q.force_fc;
  assign hps_override  = ctrl_q.hps_override;
  assign PD            = pd_q;
  assign hps_SOUT      = sout_q;
  assign hps_LAT       = lat_q;
  assign hps_SCLK      = sclk_q;
  assign hps_turn_tick = tick_q;

endmodule
